// File: rtl/scope_pkg.sv
// scope_pkg: shared types for the XADC capture path.
// Sample-pair layout and capture FSM states.
package scope_pkg;

  localparam int SAMPLE_W = 12;
  localparam int NUM_CH   = 2;
  localparam int PAIR_W   = NUM_CH * SAMPLE_W;

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] sample_pair_t;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POSTTRIG,
    DONE
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x PAIR_W simple dual-port RAM.
// One write port, one registered read port (BRAM style).
module capture_ram
  import scope_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PAIR_W-1:0] rd_data
);

  logic [PAIR_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port, one cycle latency.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: circular capture of XADC sample pairs with a
// level trigger, then oldest-first readout over valid/ready.
module trigger_capture
  import scope_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [1:0][11:0]  samples,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              trig_channel,
  input  logic              trig_rising,
  input  logic [11:0]       trig_level,
  input  logic [ADDR_W-1:0] pretrig,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0][11:0]  out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  cap_state_e state;
  cap_state_e state_nxt;

  logic [ADDR_W-1:0] pretrig_l;
  logic              ch_l;
  logic              rising_l;
  logic [11:0]       lvl_l;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_ptr;
  logic [11:0]       prev;
  logic              prev_valid;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_cnt;
  logic              issue;
  logic              pend;

  logic              capturing;
  logic              accept;
  logic [11:0]       cur;
  logic              edge_hit;
  logic              trig_fire;
  logic [ADDR_W-1:0] post_init;
  logic [ADDR_W-1:0] rd_base;
  logic              hs;
  logic              arm_go;
  logic              enter_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PAIR_W-1:0] rd_data;

  assign capturing = (state == PRETRIG)
                  || (state == WAIT_TRIG)
                  || (state == POSTTRIG);
  assign accept    = sample_valid && capturing;
  assign cur       = samples[ch_l];

  assign edge_hit  = prev_valid && (rising_l
                   ? (prev <  lvl_l && cur >= lvl_l)
                   : (prev >= lvl_l && cur <  lvl_l));
  assign trig_fire = accept && (state == WAIT_TRIG)
                  && (edge_hit || force_trig);

  assign post_init = LAST - pretrig_l;
  assign rd_base   = trig_fire ? wr_ptr : trig_ptr;
  assign hs        = out_valid && out_ready;
  assign arm_go    = (state == IDLE) && arm && !abort;
  assign enter_done = (state != DONE) && (state_nxt == DONE);

  // Next read is either the window start or the pair after rd_ptr.
  assign rd_en   = issue || (hs && !out_last);
  assign rd_addr = issue ? rd_ptr : rd_ptr + ONE;

  assign busy = capturing;
  assign done = (state == DONE);

  capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (samples),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (arm)
            state_nxt = (pretrig == '0) ? WAIT_TRIG : PRETRIG;
        PRETRIG:
          if (accept && (pre_cnt + ONE) == pretrig_l)
            state_nxt = WAIT_TRIG;
        WAIT_TRIG:
          if (trig_fire)
            state_nxt = (post_init == '0) ? DONE : POSTTRIG;
        POSTTRIG:
          if (accept && post_cnt == ONE)
            state_nxt = DONE;
        DONE:
          if (hs && out_last)
            state_nxt = IDLE;
        default:
          state_nxt = IDLE;
      endcase
    end
  end

  // Trigger configuration is frozen at arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      pretrig_l <= '0;
      ch_l      <= 1'b0;
      rising_l  <= 1'b0;
      lvl_l     <= '0;
    end else if (arm_go) begin
      pretrig_l <= pretrig;
      ch_l      <= trig_channel;
      rising_l  <= trig_rising;
      lvl_l     <= trig_level;
    end
  end

  // Write pointer, window counters and trigger history.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_ptr   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
    end else if (arm_go) begin
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + ONE;
        prev       <= cur;
        prev_valid <= 1'b1;
      end
      if (accept && state == PRETRIG)
        pre_cnt <= pre_cnt + ONE;
      if (accept && state == POSTTRIG)
        post_cnt <= post_cnt - ONE;
      if (trig_fire) begin
        trig_ptr  <= wr_ptr;
        post_cnt  <= post_init;
        triggered <= 1'b1;
      end
      if (abort)
        triggered <= 1'b0;
    end
  end

  // Readout: one read in flight, output held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      issue     <= 1'b0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      issue <= enter_done;
      pend  <= rd_en && !abort;
      if (enter_done) begin
        rd_ptr <= rd_base - pretrig_l;
        rd_cnt <= '0;
      end
      if (pend) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == LAST);
      end
      if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (!out_last) begin
          rd_ptr <= rd_ptr + ONE;
          rd_cnt <= rd_cnt + ONE;
        end
      end
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: random and directed captures scored
// against a sample-history model of the trigger window.
module tb_trigger_capture;

  localparam int DEPTH = 16;

  typedef logic [1:0][11:0] pair_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            sample_valid;
  logic [1:0][11:0] samples;
  logic            arm;
  logic            abort;
  logic            force_trig;
  logic            trig_channel;
  logic            trig_rising;
  logic [11:0]     trig_level;
  logic [3:0]      pretrig;
  logic            busy;
  logic            triggered;
  logic            done;
  logic            out_valid;
  logic            out_ready;
  logic [1:0][11:0] out_data;
  logic            out_last;

  int n_cmp = 0;
  int n_bad = 0;

  int    cur_pt;
  int    cur_ch;
  bit    cur_rise;
  int    cur_lvl;
  bit    m_trig;
  bit    m_done;
  int    m_trig_idx;
  pair_t hist[$];
  pair_t rx[DEPTH];

  trigger_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .samples      (samples),
    .arm          (arm),
    .abort        (abort),
    .force_trig   (force_trig),
    .trig_channel (trig_channel),
    .trig_rising  (trig_rising),
    .trig_level   (trig_level),
    .pretrig      (pretrig),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // 0: ch0 ramp n*100, ch1 = n; 1: ch1 falls from 4000, ch0 = n
  // 2: constant 2048; other: random
  function automatic pair_t gen(input int mode, input int n);
    pair_t p;
    case (mode)
      0: begin p[0] = 12'(n * 100); p[1] = 12'(n); end
      1: begin p[1] = 12'(4000 - 100 * n); p[0] = 12'(n); end
      2: begin p[0] = 12'd2048; p[1] = 12'd2048; end
      default: begin p[0] = 12'($urandom); p[1] = 12'($urandom); end
    endcase
    return p;
  endfunction

  // Append an accepted sample; decide trigger and window end.
  function automatic void model_step(input pair_t s, input bit f);
    int i;
    int c;
    int p;
    bit hit;
    hist.push_back(s);
    i = hist.size() - 1;
    if (!m_trig && i >= cur_pt) begin
      hit = 1'b0;
      c = int'(s[cur_ch]);
      if (i >= 1) begin
        p = int'(hist[i-1][cur_ch]);
        hit = cur_rise ? (p < cur_lvl && c >= cur_lvl)
                       : (p >= cur_lvl && c < cur_lvl);
      end
      if (hit || f) begin
        m_trig = 1'b1;
        m_trig_idx = i;
      end
    end
    if (m_trig && hist.size() == m_trig_idx + DEPTH - cur_pt)
      m_done = 1'b1;
  endfunction

  task automatic capture(input int pt, input int ch, input bit rise,
                         input int lvl, input int mode,
                         input int force_at, input int stop_after,
                         input bit rearm);
    bit rearmed;
    bit v;
    bit f;
    int n;
    @(negedge clk);
    cur_pt = pt; cur_ch = ch; cur_rise = rise; cur_lvl = lvl;
    hist.delete();
    m_trig = 1'b0; m_done = 1'b0; m_trig_idx = -1; rearmed = 1'b0;
    pretrig = 4'(pt); trig_channel = 1'(ch);
    trig_rising = rise; trig_level = 12'(lvl);
    arm = 1'b1; abort = 1'b0;
    sample_valid = 1'b0; force_trig = 1'b0;
    @(posedge clk); #1;
    check("arm_busy", busy, 1);
    check("arm_trig", triggered, 0);
    for (int cyc = 0; cyc < 3000 && !m_done; cyc++) begin
      @(negedge clk);
      arm = 1'b0;
      pretrig = 4'($urandom);
      trig_level = 12'($urandom);
      trig_rising = 1'($urandom);
      trig_channel = 1'($urandom);
      if (rearm && !rearmed && hist.size() >= pt && !m_trig) begin
        arm = 1'b1;
        rearmed = 1'b1;
      end
      n = hist.size();
      v = ($urandom_range(3) != 0);
      if (force_at >= 0) f = (n >= force_at);
      else f = (force_at == -2) && ($urandom_range(15) == 0);
      sample_valid = v;
      force_trig = f;
      samples = gen(mode, n);
      if (v) model_step(samples, f);
      @(posedge clk); #1;
      check("triggered", triggered, m_trig);
      check("done", done, m_done);
      check("busy", busy, !m_done);
      if (stop_after >= 0 && m_trig
          && hist.size() > m_trig_idx + stop_after) break;
    end
    if (stop_after < 0 && !m_done) check("cap_timeout", 0, 1);
  endtask

  task automatic readout(input int stall, input int rst_after);
    bit    held;
    bit    rdy;
    pair_t hold_v;
    int    k;
    int    base;
    k = 0;
    held = 1'b0;
    hold_v = '0;
    base = m_trig_idx - cur_pt;
    for (int cyc = 0; cyc < 600 && k < DEPTH; cyc++) begin
      @(negedge clk);
      sample_valid = 1'($urandom);
      samples = gen(3, 0);
      force_trig = 1'($urandom);
      arm = ($urandom_range(7) == 0);
      abort = 1'b0;
      if (k == rst_after) begin
        reset = 1'b1;
        arm = 1'b0;
        sample_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_trig", triggered, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (cyc < 2) check("rd_lat", out_valid, 0);
      if (cyc == 2) check("rd_first", out_valid, 1);
      rdy = (cyc >= stall) && ($urandom_range(3) != 0);
      out_ready = rdy;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_v);
      end
      held = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          check("data", out_data, hist[base + k]);
          check("last", out_last, (k == DEPTH - 1));
          rx[k] = out_data;
          k++;
        end else begin
          held = 1'b1;
          hold_v = out_data;
        end
      end
    end
    @(negedge clk);
    arm = 1'b0;
    sample_valid = 1'b0;
    force_trig = 1'b0;
    out_ready = 1'b0;
    check("rd_count", k, DEPTH);
    check("end_done", done, 0);
    check("end_busy", busy, 0);
    check("end_trig", triggered, 1);
    check("end_valid", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    samples = '0;
    arm = 1'b0;
    abort = 1'b0;
    force_trig = 1'b0;
    trig_channel = 1'b0;
    trig_rising = 1'b1;
    trig_level = '0;
    pretrig = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", busy, 0);
    check("init_trig", triggered, 0);
    check("init_done", done, 0);
    check("init_valid", out_valid, 0);
    check("init_last", out_last, 0);
    check("init_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // Rising on ch0 ramp, trigger on 400.
    capture(4, 0, 1'b1, 350, 0, -1, -1, 1'b0);
    readout(0, -1);
    check("t1_p4", rx[4][0], 400);
    check("t1_p0", rx[0][0], 0);
    check("t1_p15", rx[15][0], 1500);

    // Falling on ch1, 3500 must not fire, 3400 does.
    capture(0, 1, 1'b0, 3500, 1, -1, -1, 1'b0);
    readout(0, -1);
    check("t2_p0", rx[0][1], 3400);

    // Forced trigger on flat input.
    capture(8, 0, 1'b1, 100, 2, 10, -1, 1'b0);
    readout(0, -1);

    // Maximum pretrig: trigger sample is the last pair.
    capture(15, 0, 1'b1, 350, 0, -1, -1, 1'b0);
    readout(0, -1);
    check("t4_p15a", rx[15][0], 404);
    check("t4_p15b", rx[15][1], 45);

    // Window wraps the RAM several times.
    capture(4, 1, 1'b1, 40, 0, -1, -1, 1'b0);
    readout(0, -1);
    check("t4_wrap0", rx[0][1], 36);
    check("t4_wrap15", rx[15][1], 51);

    // Long backpressure at the start of readout.
    capture(6, 0, 1'b1, 2048, 3, -2, -1, 1'b0);
    readout(20, -1);

    // Abort in POSTTRIG, with arm and a sample alongside.
    capture(4, 0, 1'b1, 350, 0, -1, 3, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    arm = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    check("ab_busy", busy, 0);
    check("ab_trig", triggered, 0);
    check("ab_done", done, 0);
    check("ab_valid", out_valid, 0);
    @(negedge clk);
    abort = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    check("ab_idle", busy, 0);

    // Reset in the middle of a readout.
    capture(4, 0, 1'b1, 350, 0, -1, -1, 1'b0);
    readout(0, 5);

    // Arm during WAIT_TRIG must not disturb the capture.
    capture(4, 0, 1'b1, 350, 0, -1, -1, 1'b1);
    readout(0, -1);
    check("t6_p4", rx[4][0], 400);

    // Random captures.
    for (int r = 0; r < 6; r++) begin
      capture($urandom_range(15), $urandom_range(1),
              1'($urandom), $urandom_range(3800, 200),
              3, -2, -1, 1'($urandom));
      readout($urandom_range(5), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
